// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, FSM states,
// instruction classes and the default IO window base.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } class_t;

  function automatic class_t decode_class(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the sequencer (slave side) and the
// datapath/memory system that feeds and consumes it (master side).
interface cpu_sequencer_if;
  logic [31:0] inst;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        mem_ready;

  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        reg_write;
  logic        mem_read;
  logic        io_read;
  logic        mem_write;
  logic        io_write;

  modport slave (
    input  inst, alu_result, branch_taken, mem_ready,
    output ir_write, pc_write, pc_src, reg_write,
           mem_read, io_read, mem_write, io_write
  );

  modport master (
    output inst, alu_result, branch_taken, mem_ready,
    input  ir_write, pc_write, pc_src, reg_write,
           mem_read, io_read, mem_write, io_write
  );
endinterface

// File: rtl/seq_timeout_counter.sv
// MEM-stage wait counter: cleared before each access, counts non-ready
// cycles and flags the last allowed cycle (TIMEOUT-1).
module seq_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // NOTE: state registers use non-blocking assignments and an async active-low
  // reset so every flop clears the moment rst falls, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_count <= '0;
    else if (i_clear)               r_count <= '0;
    else if (i_enable && !o_expired) r_count <= r_count + ONE;
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory
// timeout, illegal-opcode trap and retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int          TIMEOUT = 16,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.slave   bus,
  output logic [2:0]       o_state,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1);

  state_t           r_state, w_next;
  class_t           r_class;
  logic             r_is_io;
  logic             r_illegal, r_bus_err;
  logic [CNT_W-1:0] r_retired;

  logic w_retire, w_set_illegal, w_set_bus_err;
  logic w_expired, w_is_load, w_is_store;
  logic w_unused_inst;

  assign w_is_load     = (r_class == CLS_LOAD);
  assign w_is_store    = (r_class == CLS_STORE);
  assign w_unused_inst = ^bus.inst[31:7];

  seq_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ST_EXEC),
    .i_enable  ((r_state == ST_MEM) && !bus.mem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_class   <= CLS_R;
      r_is_io   <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_class <= decode_class(bus.inst[6:0]);
      if (r_state == ST_EXEC && (w_is_load || w_is_store))
        r_is_io <= (bus.alu_result >= IO_BASE);
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_retire)      r_retired <= r_retired + RET_ONE;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (decode_class(bus.inst[6:0]) == CLS_ILLEGAL) begin
          w_next        = ST_TRAP;
          w_set_illegal = 1'b1;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_class)
          CLS_R, CLS_I:        w_next = ST_WB;
          CLS_LOAD, CLS_STORE: w_next = ST_MEM;
          CLS_BRANCH: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
          default:             w_next = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        // A ready on the final allowed cycle completes the access normally.
        if (bus.mem_ready) begin
          if (w_is_store) begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next        = ST_TRAP;
          w_set_bus_err = 1'b1;
        end
      end
      ST_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.io_read   = 1'b0;
    bus.mem_write = 1'b0;
    bus.io_write  = 1'b0;
    case (r_state)
      ST_FETCH: bus.ir_write = 1'b1;
      ST_EXEC: begin
        if (r_class == CLS_BRANCH) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.branch_taken;
        end
      end
      ST_MEM: begin
        bus.mem_read  = w_is_load  && !r_is_io;
        bus.io_read   = w_is_load  &&  r_is_io;
        bus.mem_write = w_is_store && !r_is_io;
        bus.io_write  = w_is_store &&  r_is_io;
        bus.pc_write  = w_is_store && bus.mem_ready;
      end
      ST_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.mem_read  = w_is_load && !r_is_io;
        bus.io_read   = w_is_load &&  r_is_io;
      end
      default: ;
    endcase
  end

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_bus_err = r_bus_err;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle outputs, a
// negedge monitor pops and compares them against the sequencer.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] S_IR  = 8'h80, S_PCW = 8'h40, S_PCS = 8'h20, S_RW  = 8'h10,
                         S_MR  = 8'h08, S_IOR = 8'h04, S_MW  = 8'h02, S_IOW = 8'h01;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  stb;
    logic        ill;
    logic        berr;
    logic [31:0] ret;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  w_state;
  logic        w_illegal, w_bus_err;
  logic [31:0] w_retired;

  cpu_sequencer_if bus_if ();

  cpu_sequencer #(.IO_BASE(32'hFFFF_FC00), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .o_state   (w_state),
    .o_illegal (w_illegal),
    .o_bus_err (w_bus_err),
    .o_retired (w_retired)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  obs_t        exp_q[$];
  logic [31:0] exp_ret  = '0;
  logic        exp_ill  = 1'b0;
  logic        exp_berr = 1'b0;

  function automatic obs_t observe();
    obs_t o;
    o.st   = w_state;
    o.stb  = {bus_if.ir_write, bus_if.pc_write, bus_if.pc_src, bus_if.reg_write,
              bus_if.mem_read, bus_if.io_read, bus_if.mem_write, bus_if.io_write};
    o.ill  = w_illegal;
    o.berr = w_bus_err;
    o.ret  = w_retired;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got st=%0d stb=%b ill=%b berr=%b ret=%0d, required st=%0d stb=%b ill=%b berr=%b ret=%0d",
                  name, act.st, act.stb, act.ill, act.berr, act.ret,
                  req.st, req.stb, req.ill, req.berr, req.ret);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle@%0t", $time), observe(), e);
      end
    end
  end

  // Called at posedge+1: records what this cycle must show, then advances.
  task automatic cyc(input state_t st, input logic [7:0] stb, input logic rdy, input logic ret);
    obs_t e;
    bus_if.mem_ready = rdy;
    e.st = st; e.stb = stb; e.ill = exp_ill; e.berr = exp_berr; e.ret = exp_ret;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus_if.mem_ready = 1'b0;
    if (ret) exp_ret++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_if.inst = '0; bus_if.alu_result = '0; bus_if.branch_taken = 1'b0; bus_if.mem_ready = 1'b0;
    exp_ret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    #1;
    check("reset_outputs", observe(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(ST_IDLE, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_inst(input logic [31:0] inst, input logic [31:0] alu, input logic br);
    bus_if.inst = inst; bus_if.alu_result = alu; bus_if.branch_taken = br;
  endtask

  task automatic front_end();
    cyc(ST_FETCH,  S_IR,  1'b0, 1'b0);
    cyc(ST_DECODE, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_alu(input logic [31:0] inst);
    set_inst(inst, 32'h0000_1234, 1'b0);
    front_end();
    cyc(ST_EXEC, 8'h00, 1'b0, 1'b0);
    cyc(ST_WB, S_RW | S_PCW, 1'b0, 1'b1);
  endtask

  task automatic run_branch(input logic [31:0] inst, input logic taken);
    set_inst(inst, 32'h0, taken);
    front_end();
    cyc(ST_EXEC, S_PCW | (taken ? S_PCS : 8'h00), 1'b0, 1'b1);
  endtask

  task automatic run_mem(input logic [31:0] inst, input logic [31:0] addr,
                         input logic store, input logic io, input int waits);
    logic [7:0] sel;
    sel = store ? (io ? S_IOW : S_MW) : (io ? S_IOR : S_MR);
    set_inst(inst, addr, 1'b0);
    front_end();
    cyc(ST_EXEC, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) cyc(ST_MEM, sel, 1'b0, 1'b0);
    if (store) begin
      cyc(ST_MEM, sel | S_PCW, 1'b1, 1'b1);
    end else begin
      cyc(ST_MEM, sel, 1'b1, 1'b0);
      cyc(ST_WB, sel | S_RW | S_PCW, 1'b0, 1'b1);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    obs_t e;
    do_reset();
    run_alu(32'h0020_81B3);                            // add
    run_alu(32'h0010_8093);                            // addi
    run_mem(32'h0000_A183, 32'h0000_0010, 1'b0, 1'b0, 2);  // lw, memory, 2 waits
    run_mem(32'h0020_A023, 32'hFFFF_FC60, 1'b1, 1'b1, 0);  // sw, IO, immediate ready
    run_branch(32'h0020_8063, 1'b1);                   // beq taken
    run_branch(32'h0020_8063, 1'b0);                   // beq not taken
    run_mem(32'h0000_A183, 32'hFFFF_FC00, 1'b0, 1'b1, 1);  // lw at IO base
    run_mem(32'h0020_A023, 32'hFFFF_FBFF, 1'b1, 1'b0, 1);  // sw just below IO base
    run_mem(32'h0000_A183, 32'h0000_0040, 1'b0, 1'b0, TIMEOUT - 1); // ready on last cycle

    // Load that never gets ready: TIMEOUT MEM cycles, then sticky bus error.
    set_inst(32'h0000_A183, 32'h0000_0020, 1'b0);
    front_end();
    cyc(ST_EXEC, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) cyc(ST_MEM, S_MR, 1'b0, 1'b0);
    exp_berr = 1'b1;
    for (int i = 0; i < 3; i++) cyc(ST_TRAP, 8'h00, 1'b0, 1'b0);
    drain();

    // Async reset asserted in the middle of a MEM cycle.
    do_reset();
    set_inst(32'h0000_A183, 32'hFFFF_FD00, 1'b0);
    front_end();
    cyc(ST_EXEC, 8'h00, 1'b0, 1'b0);
    bus_if.mem_ready = 1'b0;
    e.st = ST_MEM; e.stb = S_IOR; e.ill = 1'b0; e.berr = 1'b0; e.ret = exp_ret;
    exp_q.push_back(e);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_reset_mid_mem", observe(), '0);

    // Unsupported opcode traps and leaves the counter alone.
    do_reset();
    run_alu(32'h0020_81B3);
    set_inst(32'h0000_0037, 32'h0, 1'b0);              // lui
    front_end();
    exp_ill = 1'b1;
    for (int i = 0; i < 3; i++) cyc(ST_TRAP, 8'h00, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
